// File: rtl/block_read_checker_if.sv
// Bus bundle between a block-read requester/memory and block_read_checker.
// Both sides share WIDTH/DEPTH so result widths track the block size.
interface block_read_checker_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                    start;
  logic                    EN_blockRead;
  logic                    VALID_memVal;
  logic [WIDTH-1:0]        memVal_data;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic                    timeout;
  logic [ADDR_W:0]         err_count;
  logic [ADDR_W-1:0]       first_err_idx;
  logic [ADDR_W:0]         beat_count;
  logic [WIDTH+ADDR_W-1:0] checksum;

  modport master (
    output start, VALID_memVal, memVal_data,
    input  EN_blockRead, busy, done, pass, timeout,
           err_count, first_err_idx, beat_count, checksum
  );

  modport slave (
    input  start, VALID_memVal, memVal_data,
    output EN_blockRead, busy, done, pass, timeout,
           err_count, first_err_idx, beat_count, checksum
  );
endinterface

// File: rtl/block_read_checker.sv
// Requests one block read and checks every beat against idx*idx, with an idle timeout.
// Optional checksum accumulator enabled by BLOCK_READ_CHECKER_CHECKSUM_EN.
module block_read_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  block_read_checker_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int CS_W   = WIDTH + ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COLLECT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [ADDR_W:0]     err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic [ADDR_W:0]     beat_q, beat_d;
  logic                timeout_q, timeout_d;
  logic                pass_q, pass_d;

  logic [2*ADDR_W-1:0] prod;
  logic [WIDTH-1:0]    expected;

  // Square is formed at 2*ADDR_W bits and only then resized to the word width.
  assign prod     = (2*ADDR_W)'(idx_q) * (2*ADDR_W)'(idx_q);
  assign expected = WIDTH'(prod);

`ifdef BLOCK_READ_CHECKER_CHECKSUM_EN
  logic [CS_W-1:0] sum_q, sum_d;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    idle_d    = idle_q;
    err_d     = err_q;
    first_d   = first_q;
    beat_d    = beat_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
`ifdef BLOCK_READ_CHECKER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_REQ;
          idx_d     = '0;
          idle_d    = '0;
          err_d     = '0;
          first_d   = '0;
          beat_d    = '0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
`ifdef BLOCK_READ_CHECKER_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      S_REQ: state_d = S_COLLECT;
      S_COLLECT: begin
        // A beat in the expiry cycle takes precedence over the timeout.
        if (bus.VALID_memVal) begin
          idx_d  = idx_q + 1'b1;
          beat_d = beat_q + 1'b1;
          idle_d = '0;
`ifdef BLOCK_READ_CHECKER_CHECKSUM_EN
          sum_d  = sum_q + CS_W'(bus.memVal_data);
`endif
          if (bus.memVal_data != expected) begin
            if (err_q == '0) first_d = idx_q;
            if (err_q != (ADDR_W+1)'(DEPTH)) err_d = err_q + 1'b1;
          end
          if (idx_q == ADDR_W'(DEPTH - 1)) state_d = S_DONE;
        end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Verdict is latched on entry to DONE so it is valid together with done.
    if (state_q == S_COLLECT && state_d == S_DONE)
      pass_d = (err_d == '0) && !timeout_d && (beat_d == (ADDR_W+1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      idle_q    <= '0;
      err_q     <= '0;
      first_q   <= '0;
      beat_q    <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      first_q   <= first_d;
      beat_q    <= beat_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
    end
  end

`ifdef BLOCK_READ_CHECKER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end
  assign bus.checksum = sum_q;
`else
  assign bus.checksum = '0;
`endif

  assign bus.EN_blockRead  = (state_q == S_REQ);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.pass          = pass_q;
  assign bus.timeout       = timeout_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;
  assign bus.beat_count    = beat_q;
endmodule
